d_latch_wr_arbiter: RTL and testbench

Round-robin write controller that shares one DW-bit bank of transparent D latches (d/en/rstn style) among NREQ requesters. It arbitrates pending write requests, drives the latch data and enable with a programmed setup/open/hold sequence, and acknowledges the served requester. It sits between the requester logic and the latch bank. It is the only block allowed to drive the bank's d and en inputs.

---
 rtl/d_latch_wr_arbiter.sv | 173 +++++++++++++++++
 tb/tb_d_latch_wr_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/d_latch_wr_arbiter.sv
// rtl/d_latch_wr_arbiter.sv - round-robin write controller for a shared transparent D-latch bank
//
// Arbitrates NREQ level-held write requests and drives one DW-bit latch bank
// through a setup / open / hold sequence, then acknowledges the served requester.
//
// Ports:
//   clk     in   clock, all state changes on the rising edge
//   rstn    in   asynchronous active-low reset
//   req     in   [NREQ]     per-requester write request, held until ack
//   wdata   in   [NREQ*DW]  requester data, slice k = wdata[k*DW +: DW]
//   gnt     out  [NREQ]     one-hot grant, grant edge through DONE
//   ack     out  [NREQ]     one-hot single-cycle pulse in DONE
//   lat_d   out  [DW]       latch bank data
//   lat_en  out  1          latch bank enable
//   busy    out  1          high in every state except IDLE
module d_latch_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int SETUP_CYC = 1,
  parameter int OPEN_CYC  = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [DW-1:0]     lat_d,
  output logic              lat_en,
  output logic              busy
);

  localparam int MAX_SO = (SETUP_CYC > OPEN_CYC) ? SETUP_CYC : OPEN_CYC;
  localparam int MAXC   = (MAX_SO > HOLD_CYC) ? MAX_SO : HOLD_CYC;
  localparam int CW     = $clog2(MAXC + 1);
  localparam int IW     = $clog2(NREQ);

  localparam logic [CW-1:0] S_LAST  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] O_LAST  = CW'(OPEN_CYC - 1);
  localparam logic [CW-1:0] H_LAST  = CW'(HOLD_CYC - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NREQ - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    OPEN  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [IW-1:0]   rr, rr_n;
  logic [IW-1:0]   win, win_n;
  logic [NREQ-1:0] gnt_n, ack_n;
  logic [DW-1:0]   lat_d_n;
  logic            lat_en_n, busy_n;

  logic            found;
  logic [IW-1:0]   pick;
  logic [DW-1:0]   pick_data;

  // Round-robin search: first requester at or above rr, wrapping modulo NREQ.
  always_comb begin
    found     = 1'b0;
    pick      = '0;
    pick_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = int'(rr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found     = 1'b1;
        pick      = IW'(idx);
        pick_data = wdata[idx*DW +: DW];
      end
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rr_n     = rr;
    win_n    = win;
    gnt_n    = gnt;
    ack_n    = '0;
    lat_d_n  = lat_d;
    lat_en_n = lat_en;
    busy_n   = busy;

    case (state)
      IDLE: begin
        if (found) begin
          state_n     = SETUP;
          win_n       = pick;
          gnt_n       = '0;
          gnt_n[pick] = 1'b1;
          lat_d_n     = pick_data;
          busy_n      = 1'b1;
          cnt_n       = '0;
        end
      end
      SETUP: begin
        if (cnt == S_LAST) begin
          state_n  = OPEN;
          cnt_n    = '0;
          lat_en_n = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      OPEN: begin
        if (cnt == O_LAST) begin
          state_n  = HOLD;
          cnt_n    = '0;
          lat_en_n = 1'b0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      HOLD: begin
        if (cnt == H_LAST) begin
          state_n    = DONE;
          cnt_n      = '0;
          ack_n[win] = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DONE: begin
        // lat_d is left alone so the bank input stays stable until the next grant.
        state_n = IDLE;
        cnt_n   = '0;
        gnt_n   = '0;
        busy_n  = 1'b0;
        rr_n    = (win == IDX_MAX) ? '0 : win + IW'(1);
      end
      default: begin
        state_n  = IDLE;
        cnt_n    = '0;
        gnt_n    = '0;
        lat_en_n = 1'b0;
        busy_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      cnt    <= '0;
      rr     <= '0;
      win    <= '0;
      gnt    <= '0;
      ack    <= '0;
      lat_d  <= '0;
      lat_en <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      rr     <= rr_n;
      win    <= win_n;
      gnt    <= gnt_n;
      ack    <= ack_n;
      lat_d  <= lat_d_n;
      lat_en <= lat_en_n;
      busy   <= busy_n;
    end
  end

endmodule

// File: tb/tb_d_latch_wr_arbiter.sv
// tb/tb_d_latch_wr_arbiter.sv - directed self-checking bench for d_latch_wr_arbiter
module tb_d_latch_wr_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [7:0]  lat_d;
  logic        lat_en;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  d_latch_wr_arbiter #(
    .NREQ(4), .DW(8), .SETUP_CYC(1), .OPEN_CYC(2), .HOLD_CYC(1)
  ) dut (
    .clk(clk), .rstn(rstn), .req(req), .wdata(wdata),
    .gnt(gnt), .ack(ack), .lat_d(lat_d), .lat_en(lat_en), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] exp_ack [6];
  int         exp_cyc [6];
  int         cyc;
  int         nacks;
  logic [3:0] drop;

  initial begin
    // Reset with all requests pending
    rstn  = 1'b0;
    req   = 4'b1111;
    wdata = 32'h3C_A5_22_11;
    step(); step();
    chk("rst_gnt",    {28'd0, gnt},    32'h0);
    chk("rst_ack",    {28'd0, ack},    32'h0);
    chk("rst_lat_en", {31'd0, lat_en}, 32'h0);
    chk("rst_lat_d",  {24'd0, lat_d},  32'h0);
    chk("rst_busy",   {31'd0, busy},   32'h0);

    // First edge after release grants req0
    rstn = 1'b1;
    step();
    chk("rel_gnt",   {28'd0, gnt},   32'h1);
    chk("rel_lat_d", {24'd0, lat_d}, 32'h11);
    chk("rel_busy",  {31'd0, busy},  32'h1);

    // Async reset mid-SETUP clears outputs without a clock edge
    #2 rstn = 1'b0;
    #1;
    chk("async_gnt",  {28'd0, gnt},  32'h0);
    chk("async_busy", {31'd0, busy}, 32'h0);

    // Single write: req2 with A5
    req   = 4'b0100;
    wdata = 32'h00_A5_00_00;
    step();
    rstn = 1'b1;
    step();                                        // edge 0
    chk("sw_gnt",     {28'd0, gnt},    32'h4);
    chk("sw_lat_d0",  {24'd0, lat_d},  32'hA5);
    chk("sw_lat_en0", {31'd0, lat_en}, 32'h0);
    chk("sw_busy0",   {31'd0, busy},   32'h1);
    wdata[23:16] = 8'h3C;
    step();                                        // edge 1
    chk("sw_lat_en1", {31'd0, lat_en}, 32'h1);
    chk("sw_lat_d1",  {24'd0, lat_d},  32'hA5);
    step();                                        // edge 2
    chk("sw_lat_en2", {31'd0, lat_en}, 32'h1);
    chk("sw_ack2",    {28'd0, ack},    32'h0);
    step();                                        // edge 3
    chk("sw_lat_en3", {31'd0, lat_en}, 32'h0);
    chk("sw_lat_d3",  {24'd0, lat_d},  32'hA5);
    step();                                        // edge 4
    chk("sw_ack4",    {28'd0, ack},    32'h4);
    chk("sw_gnt4",    {28'd0, gnt},    32'h4);
    chk("sw_busy4",   {31'd0, busy},   32'h1);
    chk("sw_lat_d4",  {24'd0, lat_d},  32'hA5);
    step();                                        // edge 5
    req = 4'b0000;
    chk("sw_busy5",   {31'd0, busy},   32'h0);
    chk("sw_ack5",    {28'd0, ack},    32'h0);
    chk("sw_gnt5",    {28'd0, gnt},    32'h0);
    chk("sw_lat_d5",  {24'd0, lat_d},  32'hA5);
    step();
    chk("sw_idle",    {31'd0, busy},   32'h0);

    // Round-robin from pointer 0, then wrap with req=1001
    exp_ack[0] = 4'b0001; exp_cyc[0] = 4;
    exp_ack[1] = 4'b0010; exp_cyc[1] = 10;
    exp_ack[2] = 4'b0100; exp_cyc[2] = 16;
    exp_ack[3] = 4'b1000; exp_cyc[3] = 22;
    exp_ack[4] = 4'b0001; exp_cyc[4] = 28;
    exp_ack[5] = 4'b1000; exp_cyc[5] = 34;
    rstn = 1'b0;
    req  = 4'b1111;
    wdata = 32'h44_33_22_11;
    step();
    rstn = 1'b1;
    cyc = 0; nacks = 0; drop = 4'b0000;
    while (nacks < 6 && cyc < 60) begin
      step();
      if (drop != 4'b0000) begin
        req  = req & ~drop;
        drop = 4'b0000;
        if (nacks == 4) req = 4'b1001;
      end
      if (cyc == 24) chk("wrap_gnt0", {28'd0, gnt}, 32'h1);
      if (cyc == 30) chk("wrap_gnt3", {28'd0, gnt}, 32'h8);
      if (ack != 4'b0000) begin
        chk($sformatf("rr_ack%0d", nacks), {28'd0, ack}, {28'd0, exp_ack[nacks]});
        chk($sformatf("rr_cyc%0d", nacks), cyc, exp_cyc[nacks]);
        drop = ack;
        nacks++;
      end
      cyc++;
    end
    chk("rr_count", nacks, 6);
    step();
    req = 4'b0000;
    step(); step();

    // Reset in the middle of OPEN
    wdata = 32'h00_A5_5A_00;
    req   = 4'b0100;
    step();                                        // grant
    chk("mo_gnt", {28'd0, gnt}, 32'h4);
    step();                                        // OPEN
    chk("mo_lat_en", {31'd0, lat_en}, 32'h1);
    #2 rstn = 1'b0;
    #1;
    chk("mo_lat_en_rst", {31'd0, lat_en}, 32'h0);
    chk("mo_gnt_rst",    {28'd0, gnt},    32'h0);
    chk("mo_busy_rst",   {31'd0, busy},   32'h0);
    chk("mo_lat_d_rst",  {24'd0, lat_d},  32'h0);
    req = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mo_no_ack", {28'd0, ack}, 32'h0);
    end
    rstn = 1'b1;
    step();
    chk("mo_regnt",  {28'd0, gnt},   32'h2);
    chk("mo_lat_d",  {24'd0, lat_d}, 32'h5A);
    chk("mo_busy",   {31'd0, busy},  32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
